// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative signed multiply (radix-2 Booth) / divide (restoring)
// Revision : 1.0  initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dbz
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0]    c_IDLE = 2'd0;
    localparam logic [1:0]    c_RUN  = 2'd1;
    localparam logic [1:0]    c_FIX  = 2'd2;
    localparam logic [1:0]    c_DONE = 2'd3;
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_op;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_q1;
    logic [WIDTH-1:0] r_hw;     // Booth accumulator / partial remainder
    logic [WIDTH-1:0] r_lw;     // multiplier / dividend-then-quotient
    logic [WIDTH-1:0] r_m;      // multiplicand / divisor magnitude
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dbz;

    logic             w_accept;
    logic [WIDTH:0]   w_booth_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;

    assign busy     = (r_state == c_RUN) || (r_state == c_FIX);
    assign done     = (r_state == c_DONE);
    assign hi       = r_hi;
    assign lo       = r_lo;
    assign dbz      = r_dbz;
    assign w_accept = start && !busy;
    assign w_abs_a  = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign w_abs_b  = b[WIDTH-1] ? (~b + 1'b1) : b;

    // Sum kept one bit wider so the arithmetic shift never loses the sign
    always_comb begin
        w_booth_sum = {r_hw[WIDTH-1], r_hw};
        case ({r_lw[0], r_q1})
            2'b10:   w_booth_sum = {r_hw[WIDTH-1], r_hw} - {r_m[WIDTH-1], r_m};
            2'b01:   w_booth_sum = {r_hw[WIDTH-1], r_hw} + {r_m[WIDTH-1], r_m};
            default: w_booth_sum = {r_hw[WIDTH-1], r_hw};
        endcase
    end

    assign w_shift = {r_hw, r_lw[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_m};

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_op    <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_q1    <= 1'b0;
            r_hw    <= '0;
            r_lw    <= '0;
            r_m     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                c_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_op) begin
                        if (!w_diff[WIDTH]) begin
                            r_hw <= w_diff[WIDTH-1:0];
                            r_lw <= {r_lw[WIDTH-2:0], 1'b1};
                        end else begin
                            r_hw <= w_shift[WIDTH-1:0];
                            r_lw <= {r_lw[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_hw <= w_booth_sum[WIDTH:1];
                        r_lw <= {w_booth_sum[0], r_lw[WIDTH-1:1]};
                        r_q1 <= r_lw[0];
                    end
                    if (r_cnt == c_LAST) begin
                        r_state <= c_FIX;
                    end
                end
                c_FIX: begin
                    if (r_op) begin
                        r_hi <= r_neg_r ? (~r_hw + 1'b1) : r_hw;
                        r_lo <= r_neg_q ? (~r_lw + 1'b1) : r_lw;
                    end else begin
                        r_hi <= r_hw;
                        r_lo <= r_lw;
                    end
                    r_dbz   <= 1'b0;
                    r_state <= c_DONE;
                end
                default: begin
                    if (w_accept) begin
                        r_op  <= op;
                        r_cnt <= '0;
                        r_hw  <= '0;
                        r_q1  <= 1'b0;
                        if (op && (b == '0)) begin
                            r_hi    <= a;
                            r_lo    <= '1;
                            r_dbz   <= 1'b1;
                            r_state <= c_DONE;
                        end else if (op) begin
                            r_m     <= w_abs_b;
                            r_lw    <= w_abs_a;
                            r_neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            r_neg_r <= a[WIDTH-1];
                            r_state <= c_RUN;
                        end else begin
                            r_m     <= a;
                            r_lw    <= b;
                            r_state <= c_RUN;
                        end
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
